debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Multi-channel, parametrised debouncer: CHANNELS independent inputs, each synchronised, filtered against a runtime-programmable stable-time threshold, and decoded into level, rising/falling pulses and a long-press pulse.
- A shared prescaler generates a timebase tick, so long debounce times need only narrow per-channel counters.
- Sits between raw button/switch pins and control logic; replaces per-pin single-channel debouncers.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- PRESCALE_L2, 10, tick period = 2^PRESCALE_L2 clocks (>=1).
- CNT_W, 8, width of per-channel debounce/hold counters and threshold inputs.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_din  in  CHANNELS  raw asynchronous inputs, bit n = channel n.
- i_threshold  in  CNT_W  debounce threshold in ticks, shared by all channels.
- i_hold_threshold  in  CNT_W  long-press threshold in ticks; 0 disables o_hold.
- o_dout  out  CHANNELS  debounced level.
- o_onhigh  out  CHANNELS  1-cycle pulse on debounced rise.
- o_onlow  out  CHANNELS  1-cycle pulse on debounced fall.
- o_hold  out  CHANNELS  1-cycle pulse when level held high for i_hold_threshold ticks.
- o_tick  out  1  prescaler tick, for observability.

Behaviour:
- Reset (i_rst=1 at a rising edge): all sync flops, o_dout, o_onhigh, o_onlow, o_hold, counters, prescaler, o_tick -> 0 at that edge. Reset mid-operation aborts all pending counts; no pulses are generated by reset itself.
- Prescaler: free-running PRESCALE_L2-bit counter. o_tick is registered, high for exactly 1 cycle when the counter wraps from all-ones to 0. First tick occurs 2^PRESCALE_L2 cycles after reset release.
- Synchroniser: per channel, SYNC_STAGES shift; raw_n = last stage. Input-to-raw latency = SYNC_STAGES cycles.
- Debounce counter, per channel, evaluated every cycle:
  - raw_n == o_dout[n]: cnt <= 0, regardless of tick.
  - mismatch, no tick: cnt holds.
  - mismatch, tick, cnt >= i_threshold: o_dout[n] toggles, cnt <= 0.
  - mismatch, tick, cnt < i_threshold: cnt <= cnt+1.
  - Net requirement: the mismatch must persist across i_threshold+1 consecutive ticks. i_threshold=0 means toggle on the first tick that sees a mismatch.
  - Any single-cycle return to agreement restarts the count.
- i_threshold is treated as quasi-static. A change takes effect at the next comparison. cnt never exceeds 2^CNT_W-1, since the comparison caps it at i_threshold.
- Edge pulses: registered, asserted in the same cycle o_dout[n] first shows its new value, for exactly 1 cycle. o_onhigh and o_onlow are mutually exclusive per channel. At most one toggle per channel per tick, so a pulse never lasts more than 1 cycle.
- Hold detector, per channel:
  - hcnt clears whenever o_dout[n]=0.
  - While o_dout[n]=1 and tick: hcnt increments, saturating at 2^CNT_W-1.
  - o_hold[n] pulses 1 cycle on the tick where hcnt transitions to equal i_hold_threshold (nonzero), at most once per high period.
  - i_hold_threshold=0: o_hold never asserts.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

Test Plan:
- Reset/idle: hold i_rst 3 cycles, i_din=0 -> all outputs 0.
  - o_tick first high exactly 2^PRESCALE_L2 cycles after release.
- Clean press (PRESCALE_L2=2, i_threshold=3): ch0 0->1 and held -> o_dout[0] rises on the 4th tick after raw_0 goes high.
  - o_onhigh[0] high exactly 1 cycle in that cycle; other channels unchanged.
- Glitch rejection (same config): ch1 high for 3 ticks then low -> o_dout[1] stays 0, no pulses.
  - Repeat with a 1-cycle dropout mid-press -> count restarts; rise occurs 4 ticks after the dropout.
- Release and simultaneous channels: ch0 and ch2 both released in the same cycle after being stable high -> o_onlow[0] and o_onlow[2] pulse in the same cycle.
  - i_threshold=0 -> change seen on the first tick.
- Long press (i_hold_threshold=5): hold ch3 high -> single o_hold[3] pulse 5 ticks after o_dout[3] rises, none afterwards.
  - i_hold_threshold=0 -> no o_hold.
- Reset mid-count: assert i_rst while ch0 cnt=2 -> next cycle cnt=0, o_dout=0, no o_onlow pulse.
  - After release, the full debounce interval is required again.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser, tick-based stable-time filter,
// edge pulses and a long-press pulse, all sharing one prescaler timebase.
module debounce_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_L2 = 10,
  parameter int CNT_W       = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CHANNELS-1:0] i_din,
  input  logic [CNT_W-1:0]    i_threshold,
  input  logic [CNT_W-1:0]    i_hold_threshold,
  output logic [CHANNELS-1:0] o_dout,
  output logic [CHANNELS-1:0] o_onhigh,
  output logic [CHANNELS-1:0] o_onlow,
  output logic [CHANNELS-1:0] o_hold,
  output logic                o_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PRESCALE_L2-1:0] pre_cnt_reg;
  logic                   tick_reg;

  // Tick is registered off the all-ones state so it lands on the wrap to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + 1'b1;
      tick_reg    <= &pre_cnt_reg;
    end
  end

  assign o_tick = tick_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [CNT_W-1:0]       hcnt_reg, hcnt_next;
    logic                   dout_reg, dout_next;
    logic                   onhigh_reg, onhigh_next;
    logic                   onlow_reg, onlow_next;
    logic                   hold_reg, hold_next;
    logic                   raw;

    assign raw = sync_reg[SYNC_STAGES-1];

    always_comb begin
      cnt_next    = cnt_reg;
      dout_next   = dout_reg;
      onhigh_next = 1'b0;
      onlow_next  = 1'b0;
      if (raw == dout_reg) begin
        cnt_next = '0;
      end else if (tick_reg) begin
        // Toggle on the (threshold+1)-th consecutive tick that sees a mismatch.
        if (cnt_reg >= i_threshold) begin
          dout_next   = ~dout_reg;
          cnt_next    = '0;
          onhigh_next = ~dout_reg;
          onlow_next  = dout_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end

    always_comb begin
      hcnt_next = hcnt_reg;
      hold_next = 1'b0;
      if (!dout_reg) begin
        hcnt_next = '0;
      end else if (tick_reg && (hcnt_reg != CNT_MAX)) begin
        // Saturation stops further transitions, so the pulse fires once per high period.
        hcnt_next = hcnt_reg + 1'b1;
        hold_next = (i_hold_threshold != '0) && (hcnt_next == i_hold_threshold);
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sync_reg   <= '0;
        cnt_reg    <= '0;
        hcnt_reg   <= '0;
        dout_reg   <= 1'b0;
        onhigh_reg <= 1'b0;
        onlow_reg  <= 1'b0;
        hold_reg   <= 1'b0;
      end else begin
        sync_reg   <= {sync_reg[SYNC_STAGES-2:0], i_din[gi]};
        cnt_reg    <= cnt_next;
        hcnt_reg   <= hcnt_next;
        dout_reg   <= dout_next;
        onhigh_reg <= onhigh_next;
        onlow_reg  <= onlow_next;
        hold_reg   <= hold_next;
      end
    end

    assign o_dout[gi]   = dout_reg;
    assign o_onhigh[gi] = onhigh_reg;
    assign o_onlow[gi]  = onlow_reg;
    assign o_hold[gi]   = hold_reg;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: behavioural reference model checked every cycle,
// plus hand-computed tick counts and pulse patterns for each scenario.
module tb_debounce_multi;
  localparam int CH = 4;
  localparam int S  = 2;
  localparam int P  = 2;
  localparam int W  = 8;
  localparam int T  = 1 << P;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [CH-1:0] i_din = '0;
  logic [W-1:0]  i_threshold = 8'd3;
  logic [W-1:0]  i_hold_threshold = 8'd0;
  logic [CH-1:0] o_dout, o_onhigh, o_onlow, o_hold;
  logic          o_tick;

  debounce_multi #(.CHANNELS(CH), .SYNC_STAGES(S), .PRESCALE_L2(P), .CNT_W(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_din(i_din), .i_threshold(i_threshold),
    .i_hold_threshold(i_hold_threshold), .o_dout(o_dout), .o_onhigh(o_onhigh),
    .o_onlow(o_onlow), .o_hold(o_hold), .o_tick(o_tick)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: level per channel, count of ticks the mismatch has survived,
  // ticks spent high, and a delay line standing in for the synchroniser.
  bit            m_level [CH];
  int            m_mm    [CH];
  int            m_hc    [CH];
  logic [CH-1:0] m_dout, m_onhigh, m_onlow, m_hold;
  bit            m_tick;
  int            cyc;
  logic [CH-1:0] hist_q[$];
  logic [CH-1:0] raw_v;
  bit            tick_now;

  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < CH; c++) begin
        m_level[c] = 1'b0; m_mm[c] = 0; m_hc[c] = 0;
      end
      m_dout = '0; m_onhigh = '0; m_onlow = '0; m_hold = '0;
      m_tick = 1'b0; cyc = 0;
      hist_q = {};
      for (int s = 0; s < S; s++) hist_q.push_back('0);
    end else begin
      tick_now = m_tick;
      raw_v = hist_q[S-1];
      hist_q.push_front(i_din);
      void'(hist_q.pop_back());
      m_onhigh = '0; m_onlow = '0; m_hold = '0;
      for (int c = 0; c < CH; c++) begin
        if (m_level[c]) begin
          if (tick_now && m_hc[c] < 255) begin
            m_hc[c]++;
            if (i_hold_threshold != 0 && m_hc[c] == int'(i_hold_threshold)) m_hold[c] = 1'b1;
          end
        end else begin
          m_hc[c] = 0;
        end
        if (raw_v[c] == m_level[c]) begin
          m_mm[c] = 0;
        end else if (tick_now) begin
          m_mm[c]++;
          if (m_mm[c] >= int'(i_threshold) + 1) begin
            m_level[c] = ~m_level[c];
            m_mm[c] = 0;
            if (m_level[c]) m_onhigh[c] = 1'b1;
            else            m_onlow[c]  = 1'b1;
          end
        end
        m_dout[c] = m_level[c];
      end
      cyc++;
      m_tick = (cyc % T == 0);
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("model dout",   32'(o_dout),   32'(m_dout));
      check("model onhigh", 32'(o_onhigh), 32'(m_onhigh));
      check("model onlow",  32'(o_onlow),  32'(m_onlow));
      check("model hold",   32'(o_hold),   32'(m_hold));
      check("model tick",   32'(o_tick),   32'(m_tick));
    end
  end

  // Count ticks the DUT consumes between a raw change reaching the filter and o_dout[ch]==lvl.
  task automatic wait_level(input int ch, input logic lvl, input string name, input int exp);
    int k = 0, nt = 0;
    bit done = 1'b0;
    while (!done && k < 400) begin
      @(negedge i_clk);
      k++;
      if (o_dout[ch] === lvl) done = 1'b1;
      else if (k >= S && o_tick) nt++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout waiting for dout[%0d]=%0b", name, ch, lvl);
    end else begin
      check(name, nt, exp);
    end
  endtask

  task automatic wait_hold(input int ch, input string name, input int exp);
    int k = 0, nt = 0;
    bit done = 1'b0;
    while (!done && k < 400) begin
      @(negedge i_clk);
      k++;
      if (o_hold[ch]) done = 1'b1;
      else if (o_tick) nt++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout waiting for hold[%0d]", name, ch);
    end else begin
      check(name, nt, exp);
    end
  endtask

  task automatic count_holds(input int ch, input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge i_clk);
      if (o_hold[ch]) n++;
    end
  endtask

  initial begin
    int k, nt, nh;
    bit done;
    @(posedge i_clk);
    chk_en = 1'b1;
    repeat (3) @(negedge i_clk);
    check("reset outputs", 32'({o_dout, o_onhigh, o_onlow, o_hold, o_tick}), 32'd0);
    i_rst = 1'b0;
    k = 0;
    while (k < 50 && !o_tick) begin @(negedge i_clk); k++; end
    check("first tick latency", k, T);
    $display("reset: first tick after %0d cycles", k);

    i_din[0] = 1'b1;
    wait_level(0, 1'b1, "clean press ticks", 4);
    check("clean press onhigh", 32'(o_onhigh), 32'h1);
    check("clean press dout", 32'(o_dout), 32'h1);
    @(negedge i_clk);
    check("onhigh one cycle", 32'(o_onhigh), 32'h0);
    $display("clean press: ch0 rose");

    i_din[1] = 1'b1;
    repeat (12) @(negedge i_clk);
    i_din[1] = 1'b0;
    repeat (12) @(negedge i_clk);
    check("glitch rejected", 32'(o_dout[1]), 32'h0);
    $display("glitch: ch1 held 3 ticks, rejected");

    i_din[1] = 1'b1;
    repeat (10) @(negedge i_clk);
    i_din[1] = 1'b0;
    @(negedge i_clk);
    i_din[1] = 1'b1;
    wait_level(1, 1'b1, "dropout restart ticks", 4);
    $display("dropout: ch1 rose after restart");

    i_din[2] = 1'b1;
    wait_level(2, 1'b1, "ch2 press ticks", 4);
    repeat (8) @(negedge i_clk);
    i_din[0] = 1'b0;
    i_din[2] = 1'b0;
    k = 0; done = 1'b0;
    while (!done && k < 100) begin
      @(negedge i_clk); k++;
      if (o_onlow != '0) done = 1'b1;
    end
    check("simultaneous onlow", 32'(o_onlow), 32'h5);
    $display("release: ch0 and ch2 fell together");

    i_threshold = 8'd0;
    i_din[1] = 1'b0;
    wait_level(1, 1'b0, "threshold0 ticks", 1);
    $display("threshold 0: ch1 fell on first tick");

    i_threshold = 8'd3;
    i_hold_threshold = 8'd5;
    i_din[3] = 1'b1;
    wait_level(3, 1'b1, "ch3 press ticks", 4);
    wait_hold(3, "hold ticks", 5);
    count_holds(3, 40, nh);
    check("single hold pulse", nh, 0);
    $display("long press: ch3 hold pulse after 5 ticks");

    i_hold_threshold = 8'd0;
    i_din[3] = 1'b0;
    wait_level(3, 1'b0, "ch3 release ticks", 4);
    i_din[3] = 1'b1;
    wait_level(3, 1'b1, "ch3 repress ticks", 4);
    count_holds(3, 40, nh);
    check("hold disabled", nh, 0);
    $display("hold threshold 0: no hold pulse");

    i_din[0] = 1'b1;
    wait_level(0, 1'b1, "ch0 repress ticks", 4);
    i_din[0] = 1'b0;
    k = 0; nt = 0;
    while (nt < 2 && k < 100) begin
      @(negedge i_clk); k++;
      if (k >= S && o_tick) nt++;
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("reset mid-count dout", 32'(o_dout), 32'h0);
    check("reset mid-count pulses", 32'({o_onlow, o_onhigh, o_hold}), 32'h0);
    i_rst = 1'b0;
    i_din[0] = 1'b1;
    wait_level(0, 1'b1, "post-reset full interval", 4);
    $display("reset mid-count: counts aborted, full interval after release");

    repeat (5) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
